// File: rtl/pc_next_unit.sv
// Fetch-stage program counter with next-PC selection.
// Chooses between sequential advance, PC-relative branch, absolute jump and
// register-indirect targets, with an exception vector overriding all of them.
// A redirect that arrives while fetch is stalled is parked in a one-entry
// buffer and applied on the first ready cycle. Every PC redirect that is
// applied raises a one-cycle flush pulse.
module pc_next_unit #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 18,
  parameter int                 INC      = 4,
  parameter logic [DATA_W-1:0]  RESET_PC = '0,
  parameter logic [DATA_W-1:0]  EXC_VEC  = DATA_W'(32'h0000_0080)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [1:0]        pcsrc,
  input  logic [DATA_W-1:0] branch_pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] jump_target,
  input  logic [DATA_W-1:0] reg_target,
  input  logic              exc_valid,
  input  logic              fetch_ready,
  output logic [DATA_W-1:0] pc_out,
  output logic              pc_valid,
  output logic              redirect_pending,
  output logic              flush_out,
  output logic              align_err
);

  // What the PC register does at the coming edge, in priority order.
  typedef enum logic [2:0] {
    ACT_EXC,      // load exception vector
    ACT_REDIRECT, // load freshly selected target
    ACT_BUFFER,   // park selected target while fetch is stalled
    ACT_PENDING,  // load previously parked target
    ACT_SEQ,      // sequential advance
    ACT_HOLD      // nothing changes
  } action_e;

  localparam logic [DATA_W-1:0] INC_W = DATA_W'(INC);

  logic [DATA_W-1:0] branch_sum;
  logic [DATA_W-1:0] branch_tgt;
  logic [DATA_W-1:0] raw_tgt;
  logic [DATA_W-1:0] aligned_tgt;
  logic [DATA_W-1:0] pending_tgt;
  logic              redirect;
  logic              misaligned;
  action_e           action;

  // Target selection: branch sum wraps at DATA_W, then keeps only ADDR_W bits.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    branch_sum = branch_pc + imm;
    branch_tgt = '0;
    raw_tgt    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      branch_tgt[i] = (i < ADDR_W) ? branch_sum[i] : 1'b0;
    end
    unique case (pcsrc)
      2'd1:    raw_tgt = branch_tgt;
      2'd2:    raw_tgt = jump_target;
      2'd3:    raw_tgt = reg_target;
      default: raw_tgt = '0;
    endcase
    aligned_tgt = {raw_tgt[DATA_W-1:2], 2'b00};
    misaligned  = |raw_tgt[1:0];
    // pcsrc = 0 means "no redirect" even when redirect_valid is set.
    redirect    = redirect_valid && (pcsrc != 2'd0);
  end

  // Priority decode of the per-edge action.
  always_comb begin
    action = ACT_HOLD;
    if (exc_valid)                             action = ACT_EXC;
    else if (redirect && fetch_ready)          action = ACT_REDIRECT;
    else if (redirect)                         action = ACT_BUFFER;
    else if (redirect_pending && fetch_ready)  action = ACT_PENDING;
    else if (fetch_ready)                      action = ACT_SEQ;
    else                                       action = ACT_HOLD;
  end

  // PC, valid, pending buffer and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out           <= RESET_PC;
      pc_valid         <= 1'b0;
      redirect_pending <= 1'b0;
      pending_tgt      <= '0;
      flush_out        <= 1'b0;
      align_err        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so the pulse
      // defaults below can be overridden later in the same block without
      // creating ordering races between registers.
      flush_out <= 1'b0;
      align_err <= 1'b0;
      if (!pc_valid) begin
        // First edge after reset only validates the PC; requests are ignored.
        pc_valid <= 1'b1;
      end else begin
        // Misalignment is reported whenever a redirect target is captured,
        // either straight into the PC or into the pending buffer.
        align_err <= redirect && !exc_valid && misaligned;
        unique case (action)
          ACT_EXC: begin
            pc_out           <= EXC_VEC;
            redirect_pending <= 1'b0;
            flush_out        <= 1'b1;
          end
          ACT_REDIRECT: begin
            pc_out           <= aligned_tgt;
            redirect_pending <= 1'b0;
            flush_out        <= 1'b1;
          end
          ACT_BUFFER: begin
            pending_tgt      <= aligned_tgt;
            redirect_pending <= 1'b1;
          end
          ACT_PENDING: begin
            pc_out           <= pending_tgt;
            redirect_pending <= 1'b0;
            flush_out        <= 1'b1;
          end
          ACT_SEQ: begin
            pc_out <= pc_out + INC_W;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the next-PC rules.
module tb_pc_next_unit;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 18;
  localparam int          INC      = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] EXC_VEC  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [1:0]  pcsrc = 2'd0;
  logic [31:0] branch_pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] reg_target = '0;
  logic        exc_valid = 1'b0;
  logic        fetch_ready = 1'b0;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        redirect_pending;
  logic        flush_out;
  logic        align_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_next_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .INC(INC),
    .RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .pcsrc(pcsrc),
    .branch_pc(branch_pc), .imm(imm),
    .jump_target(jump_target), .reg_target(reg_target),
    .exc_valid(exc_valid), .fetch_ready(fetch_ready),
    .pc_out(pc_out), .pc_valid(pc_valid),
    .redirect_pending(redirect_pending),
    .flush_out(flush_out), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_pc    = longint'(RESET_PC);
  bit     m_valid = 1'b0;
  bit     m_pend  = 1'b0;
  longint m_ptgt  = 0;
  bit     m_flush = 1'b0;
  bit     m_aerr  = 1'b0;

  localparam longint MOD_D = 64'h1_0000_0000;

  function automatic longint raw_target();
    case (pcsrc)
      2'd1: return ((longint'(branch_pc) + longint'(imm)) % MOD_D) % (longint'(1) << ADDR_W);
      2'd2: return longint'(jump_target);
      2'd3: return longint'(reg_target);
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    longint raw;
    bit     redir;
    if (!rst_n) begin
      m_pc = longint'(RESET_PC); m_valid = 0; m_pend = 0; m_ptgt = 0;
      m_flush = 0; m_aerr = 0;
    end else if (!m_valid) begin
      m_valid = 1; m_flush = 0; m_aerr = 0;
    end else begin
      redir   = redirect_valid && (pcsrc != 2'd0);
      raw     = raw_target();
      m_flush = 0;
      m_aerr  = 0;
      if (exc_valid) begin
        m_pc = longint'(EXC_VEC); m_pend = 0; m_flush = 1;
      end else if (redir) begin
        m_aerr = (raw % 4) != 0;
        if (fetch_ready) begin
          m_pc = raw - raw % 4; m_pend = 0; m_flush = 1;
        end else begin
          m_ptgt = raw - raw % 4; m_pend = 1;
        end
      end else if (m_pend && fetch_ready) begin
        m_pc = m_ptgt; m_pend = 0; m_flush = 1;
      end else if (fetch_ready) begin
        m_pc = (m_pc + INC) % MOD_D;
      end
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    check("cmp_pc_out",   pc_out,                    32'(m_pc));
    check("cmp_pc_valid", {31'd0, pc_valid},         {31'd0, m_valid});
    check("cmp_pending",  {31'd0, redirect_pending}, {31'd0, m_pend});
    check("cmp_flush",    {31'd0, flush_out},        {31'd0, m_flush});
    check("cmp_align",    {31'd0, align_err},        {31'd0, m_aerr});
  end

  // One clock edge; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_req();
    redirect_valid = 0; pcsrc = 2'd0; exc_valid = 0;
  endtask

  task automatic redir(input logic [1:0] src, input logic [31:0] tgt);
    redirect_valid = 1; pcsrc = src;
    if (src == 2'd2) jump_target = tgt;
    else if (src == 2'd3) reg_target = tgt;
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_ready = 1'b1;
    #3;
    check("rst_pc",      pc_out, RESET_PC);
    check("rst_valid",   {31'd0, pc_valid}, 32'd0);
    check("rst_pending", {31'd0, redirect_pending}, 32'd0);
    check("rst_flush",   {31'd0, flush_out}, 32'd0);
    check("rst_align",   {31'd0, align_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset release and sequential advance.
    tick();
    check("seq_c1_pc", pc_out, 32'h0);
    check("seq_c1_valid", {31'd0, pc_valid}, 32'd1);
    tick(); check("seq_4", pc_out, 32'h4);
    tick(); check("seq_8", pc_out, 32'h8);
    tick(); check("seq_12", pc_out, 32'hC);
    check("seq_noflush", {31'd0, flush_out}, 32'd0);
    tick(); check("seq_16", pc_out, 32'h10);

    // Branch truncated to ADDR_W bits.
    branch_pc = 32'h0003_FFF0; imm = 32'h20; redirect_valid = 1; pcsrc = 2'd1;
    tick();
    check("br_trunc_pc", pc_out, 32'h10);
    check("br_flush", {31'd0, flush_out}, 32'd1);
    clear_req();
    tick();
    check("br_flush_pulse", {31'd0, flush_out}, 32'd0);
    check("br_seq", pc_out, 32'h14);

    // Stall buffering: newest redirect wins.
    fetch_ready = 0; redir(2'd2, 32'h400);
    tick();
    check("stall_hold1", pc_out, 32'h14);
    check("stall_pend1", {31'd0, redirect_pending}, 32'd1);
    redir(2'd3, 32'h800);
    tick();
    check("stall_hold2", pc_out, 32'h14);
    clear_req(); fetch_ready = 1;
    tick();
    check("stall_newest", pc_out, 32'h800);
    check("stall_clear", {31'd0, redirect_pending}, 32'd0);
    check("stall_flush", {31'd0, flush_out}, 32'd1);

    // Exception overrides a pending redirect.
    fetch_ready = 0; redir(2'd2, 32'h400);
    tick();
    check("exc_pend_set", {31'd0, redirect_pending}, 32'd1);
    clear_req(); exc_valid = 1;
    tick();
    check("exc_pc", pc_out, 32'h80);
    check("exc_pend_clr", {31'd0, redirect_pending}, 32'd0);
    check("exc_flush", {31'd0, flush_out}, 32'd1);
    clear_req(); fetch_ready = 1;

    // Misaligned jump.
    redir(2'd2, 32'h1003);
    tick();
    check("mis_pc", pc_out, 32'h1000);
    check("mis_align", {31'd0, align_err}, 32'd1);
    clear_req();
    tick();
    check("mis_align_pulse", {31'd0, align_err}, 32'd0);

    // Wrap-around.
    redir(2'd2, 32'hFFFF_FFFC);
    tick();
    check("wrap_pre", pc_out, 32'hFFFF_FFFC);
    clear_req();
    tick();
    check("wrap_zero", pc_out, 32'h0);

    // Reset mid-stall discards pending redirect, asynchronously.
    fetch_ready = 0; redir(2'd2, 32'h400);
    tick();
    check("rst_stall_pend", {31'd0, redirect_pending}, 32'd1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("async_rst_pc", pc_out, RESET_PC);
    check("async_rst_pend", {31'd0, redirect_pending}, 32'd0);
    check("async_rst_valid", {31'd0, pc_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1; clear_req(); fetch_ready = 1;

    // Randomized traffic checked by the model each cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 500 == 250) begin
        #2 rst_n = 0;
        #1 check("rnd_rst_pc", pc_out, RESET_PC);
        #1 rst_n = 1;
      end
      fetch_ready    = ($urandom_range(0, 9) < 7);
      exc_valid      = ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 2) == 0);
      pcsrc          = 2'($urandom_range(0, 3));
      branch_pc      = $urandom;
      imm            = $urandom_range(0, 1) ? 32'($urandom_range(0, 4095))
                                            : -32'($urandom_range(0, 4095));
      jump_target    = $urandom;
      reg_target     = $urandom;
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
